// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: latches a pattern of up to MAX_LEN bits and shifts
// it out MSB-first, repeated reps+1 times with gap idle cycles between emissions.
module seq_pattern_gen #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [CNT_W-1:0]   reps,
    input  logic [GAP_W-1:0]   gap,
    output logic               aout,
    output logic               aout_vld,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

    logic [1:0]         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [LEN_W-1:0]   bit_q, bit_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic               aout_q, aout_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   len_clamp;

    // Shift-based select keeps the index width independent of the pattern width.
    function automatic logic pick_bit(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] idx);
        logic [MAX_LEN-1:0] s;
        s = p >> idx;
        return s[0];
    endfunction

    assign len_clamp = (len > MAX_LEN_L) ? MAX_LEN_L : len;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        gcnt_d  = gcnt_q;
        aout_d  = 1'b0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    state_d = ST_IDLE;
                    if (start) begin
                        pat_d = pattern;
                        len_d = len_clamp;
                        rep_d = reps;
                        gap_d = gap;
                        if (len_clamp == '0) begin
                            state_d = ST_FIN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_SHIFT;
                            bit_d   = len_clamp - LEN_ONE;
                            aout_d  = pick_bit(pattern, len_clamp - LEN_ONE);
                            vld_d   = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bit_q != '0) begin
                        bit_d  = bit_q - LEN_ONE;
                        aout_d = pick_bit(pat_q, bit_q - LEN_ONE);
                        vld_d  = 1'b1;
                        busy_d = 1'b1;
                    end else if (rep_q == '0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        rep_d  = rep_q - CNT_ONE;
                        busy_d = 1'b1;
                        if (gap_q == '0) begin
                            bit_d  = len_q - LEN_ONE;
                            aout_d = pick_bit(pat_q, len_q - LEN_ONE);
                            vld_d  = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            gcnt_d  = gap_q - GAP_ONE;
                        end
                    end
                end
                ST_GAP: begin
                    busy_d = 1'b1;
                    if (gcnt_q == '0) begin
                        state_d = ST_SHIFT;
                        bit_d   = len_q - LEN_ONE;
                        aout_d  = pick_bit(pat_q, len_q - LEN_ONE);
                        vld_d   = 1'b1;
                    end else begin
                        gcnt_d = gcnt_q - GAP_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            gcnt_q  <= '0;
            aout_q  <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            gcnt_q  <= gcnt_d;
            aout_q  <= aout_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign aout        = aout_q;
    assign aout_vld    = vld_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: per-cycle expectations of {aout, aout_vld, busy, done}.
module tb_seq_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic [7:0]  reps = '0;
    logic [3:0]  gap = '0;
    logic        aout, aout_vld, busy, done;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    seq_pattern_gen #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8), .GAP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .reps(reps), .gap(gap),
        .aout(aout), .aout_vld(aout_vld), .busy(busy), .done(done),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Drive a launch request; the next posedge is the start edge, next negedge is cycle 1.
    task automatic launch(input logic [15:0] p, input logic [4:0] l, input logic [7:0] r,
                          input logic [3:0] g);
        pattern = p;
        len     = l;
        reps    = r;
        gap     = g;
        start   = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({aout, aout_vld, busy, done} !== 4'b0000 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold got=%b st=%0d exp=0000 st=0", {aout, aout_vld, busy, done}, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({aout, aout_vld, busy, done} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=0000", k, {aout, aout_vld, busy, done});
            end
        end
    endtask

    task automatic test_basic_rep();
        logic [3:0] exp_t [8];
        exp_t = '{4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0110, 4'b1110, 4'b0001, 4'b0000};
        launch(16'b101, 5'd3, 8'd1, 4'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({aout, aout_vld, busy, done} !== exp_t[k]) begin
                errors++;
                $display("FAIL basic_rep cyc=%0d got=%b exp=%b", k + 1, {aout, aout_vld, busy, done}, exp_t[k]);
            end
        end
    endtask

    task automatic test_gap();
        logic [3:0] exp_t [18];
        exp_t = '{4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0010, 4'b0010,
                  4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0010, 4'b0010,
                  4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0001, 4'b0000};
        launch(16'hB, 5'd4, 8'd2, 4'd2);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            start = 1'b0;
            pattern = 16'h0; // changes after latching must not disturb the run
            checks++;
            if ({aout, aout_vld, busy, done} !== exp_t[k]) begin
                errors++;
                $display("FAIL gap cyc=%0d got=%b exp=%b", k + 1, {aout, aout_vld, busy, done}, exp_t[k]);
            end
        end
    endtask

    task automatic test_len_zero();
        logic [3:0] exp_t [3];
        exp_t = '{4'b0001, 4'b0000, 4'b0000};
        launch(16'hFFFF, 5'd0, 8'd3, 4'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({aout, aout_vld, busy, done} !== exp_t[k]) begin
                errors++;
                $display("FAIL len_zero cyc=%0d got=%b exp=%b", k + 1, {aout, aout_vld, busy, done}, exp_t[k]);
            end
        end
    endtask

    task automatic test_len_clamp();
        logic [15:0] p;
        logic [3:0]  e;
        p = 16'hA5C3;
        launch(p, 5'd31, 8'd0, 4'd0);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k <= 16) e = {p[16-k], 3'b110};
            else if (k == 17) e = 4'b0001;
            else e = 4'b0000;
            checks++;
            if ({aout, aout_vld, busy, done} !== e) begin
                errors++;
                $display("FAIL len_clamp cyc=%0d got=%b exp=%b", k, {aout, aout_vld, busy, done}, e);
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] exp_t [3];
        logic [3:0] run_t [4];
        exp_t = '{4'b1110, 4'b1110, 4'b0110};
        run_t = '{4'b0110, 4'b1110, 4'b0001, 4'b0000};
        launch(16'b11011010, 5'd8, 8'd0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({aout, aout_vld, busy, done} !== exp_t[k]) begin
                errors++;
                $display("FAIL abort_pre cyc=%0d got=%b exp=%b", k + 1, {aout, aout_vld, busy, done}, exp_t[k]);
            end
        end
        abort = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            abort = 1'b0;
            checks++;
            if ({aout, aout_vld, busy, done} !== 4'b0000 || dbg_state !== 2'd0) begin
                errors++;
                $display("FAIL abort_post cyc=%0d got=%b st=%0d exp=0000 st=0", k,
                         {aout, aout_vld, busy, done}, dbg_state);
            end
        end
        launch(16'b01, 5'd2, 8'd0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({aout, aout_vld, busy, done} !== run_t[k]) begin
                errors++;
                $display("FAIL abort_rerun cyc=%0d got=%b exp=%b", k + 1, {aout, aout_vld, busy, done}, run_t[k]);
            end
        end
    endtask

    task automatic test_abort_start();
        launch(16'hFFFF, 5'd4, 8'd0, 4'd0);
        abort = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            checks++;
            if ({aout, aout_vld, busy, done} !== 4'b0000) begin
                errors++;
                $display("FAIL abort_start cyc=%0d got=%b exp=0000", k + 1, {aout, aout_vld, busy, done});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_t [10];
        exp_t = '{4'b1110, 4'b0110, 4'b0001, 4'b1110, 4'b0110, 4'b0001,
                  4'b1110, 4'b0110, 4'b0001, 4'b0000};
        launch(16'b10, 5'd2, 8'd0, 4'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 8) start = 1'b0;
            checks++;
            if ({aout, aout_vld, busy, done} !== exp_t[k]) begin
                errors++;
                $display("FAIL chain cyc=%0d got=%b exp=%b", k + 1, {aout, aout_vld, busy, done}, exp_t[k]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [3:0] exp_t [6];
        exp_t = '{4'b1110, 4'b0110, 4'b0110, 4'b1110, 4'b0001, 4'b0000};
        launch(16'b1001, 5'd4, 8'd0, 4'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) launch(16'hFFFF, 5'd8, 8'd3, 4'd0);
            else start = 1'b0;
            checks++;
            if ({aout, aout_vld, busy, done} !== exp_t[k]) begin
                errors++;
                $display("FAIL busy_start cyc=%0d got=%b exp=%b", k + 1, {aout, aout_vld, busy, done}, exp_t[k]);
            end
        end
    endtask

    task automatic test_max_reps();
        logic [3:0] e;
        launch(16'h1, 5'd1, 8'hFF, 4'd0);
        for (int k = 1; k <= 258; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k <= 256) e = 4'b1110;
            else if (k == 257) e = 4'b0001;
            else e = 4'b0000;
            checks++;
            if ({aout, aout_vld, busy, done} !== e) begin
                errors++;
                $display("FAIL max_reps cyc=%0d got=%b exp=%b", k, {aout, aout_vld, busy, done}, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] run_t [2];
        run_t = '{4'b1110, 4'b0001};
        launch(16'hFF, 5'd8, 8'd0, 4'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({aout, aout_vld, busy, done} !== 4'b1110) begin
            errors++;
            $display("FAIL areset_pre got=%b exp=1110", {aout, aout_vld, busy, done});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({aout, aout_vld, busy, done} !== 4'b0000 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL areset_now got=%b st=%0d exp=0000 st=0", {aout, aout_vld, busy, done}, dbg_state);
        end
        @(negedge clk);
        #3 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({aout, aout_vld, busy, done} !== 4'b0000) begin
                errors++;
                $display("FAIL areset_idle cyc=%0d got=%b exp=0000", k, {aout, aout_vld, busy, done});
            end
        end
        launch(16'h1, 5'd1, 8'd0, 4'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({aout, aout_vld, busy, done} !== run_t[k]) begin
                errors++;
                $display("FAIL areset_rerun cyc=%0d got=%b exp=%b", k + 1, {aout, aout_vld, busy, done}, run_t[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_rep();
        test_gap();
        test_len_zero();
        test_len_clamp();
        test_abort();
        test_abort_start();
        test_back_to_back();
        test_start_while_busy();
        test_max_reps();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
